lap_memory_reader: RTL and testbench

Playback engine for the stopwatch's lap/pause memory. The counter side writes captured tick values into an 8-bit synchronous memory. This block is the reading end of that memory. On a start request it walks a contiguous range of entries, reads each one through the memory's read port, and presents each value with its index on a valid/ready output stream for display or UART dump. It sits between the lap memory read port and the display/serial consumer.

---
 rtl/lap_memory_reader.sv | 124 ++++++++++++
 tb/tb_lap_memory_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lap_memory_reader.sv
// Playback engine for the lap/pause memory: walks a contiguous range of entries
// through the synchronous read port and streams each value with its index.
module lap_memory_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] entry_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [DATA_W-1:0] out_data_reg;
    logic [ADDR_W-1:0] out_index_reg;
    logic              out_valid_reg, busy_reg, done_reg;
    logic              handshake, last_entry;

    assign handshake  = (state_reg == S_PRESENT) && out_valid_reg && out_ready;
    assign last_entry = (idx_reg == cnt_reg - ADDR_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (entry_count != '0) begin
                        addr_next  = base_addr;
                        cnt_next   = entry_count;
                        idx_next   = '0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_FINISH;
                    end
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_PRESENT;
            S_PRESENT: begin
                if (handshake) begin
                    if (last_entry) begin
                        state_next = S_FINISH;
                    end else begin
                        addr_next  = addr_reg + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                        idx_next   = idx_reg + ADDR_W'(1);
                        state_next = S_FETCH;
                    end
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        // Abort wins over start and over a same-cycle handshake.
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg  <= '0;
            out_index_reg <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (state_reg == S_WAIT) begin
                out_data_reg  <= mem_rdata;
                out_index_reg <= idx_reg;
            end
            out_valid_reg <= (state_next == S_PRESENT);
            busy_reg      <= (state_next != S_IDLE);
            done_reg      <= (state_next == S_FINISH);
        end
    end

    assign mem_rd_en = (state_reg == S_FETCH);
    assign mem_addr  = (state_reg == S_FETCH) ? addr_reg : '0;
    assign out_data  = out_data_reg;
    assign out_index = out_index_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_lap_memory_reader.sv
// Randomized bench for lap_memory_reader: a memory array plus an expected
// stream derived from base/count arithmetic, with timing and handshake checks.
module tb_lap_memory_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, out_ready;
    logic [7:0] base_addr, entry_count;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] out_data, out_index;
    logic       out_valid, busy, done;

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;

    lap_memory_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .entry_count(entry_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_addr"},  32'(mem_addr), 0);
        check({tag, "_data"},  32'(out_data), 0);
        check({tag, "_index"}, 32'(out_index), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
    endtask

    // mode 0: ready always high (exact timing checked); 1: random ready;
    // 2: ready low for 5 cycles while entry 1 is presented.
    task automatic play(input logic [7:0] base, input logic [7:0] cnt, input int mode,
                        input int abort_idx, input int xstart_cyc);
        int k, nrd, ndone, done_c, last_vc, stall, ca;
        bit pend, hs_prev, finished, aborted;
        logic [7:0] pd, pi, ea;
        k = 0; nrd = 0; ndone = 0; done_c = -10; last_vc = 0; stall = 0; ca = 0;
        pend = 0; hs_prev = 0; finished = 0; aborted = 0; pd = 0; pi = 0;
        @(negedge clk);
        base_addr = base; entry_count = cnt; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= 400 && !finished; c++) begin
            @(negedge clk);
            start = (c == xstart_cyc);
            base_addr = 8'($urandom);
            entry_count = 8'($urandom);
            abort = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom);
                default: begin
                    if (out_valid && out_index == 8'd1 && stall < 5) begin
                        out_ready = 1'b0; stall++;
                    end else out_ready = 1'b1;
                end
            endcase
            if (aborted) out_ready = 1'b1;
            if (!aborted && abort_idx >= 0 && out_valid && out_index == 8'(abort_idx)) begin
                abort = 1'b1; out_ready = 1'b1;
            end
            #1;
            if (aborted) begin
                check("post_abort_valid", 32'(out_valid), 0);
                check("post_abort_busy", 32'(busy), 0);
                check("post_abort_done", 32'(done), 0);
                check("post_abort_rd", 32'(mem_rd_en), 0);
                if (c >= ca + 3) finished = 1;
                continue;
            end
            if (mem_rd_en) begin
                ea = base + 8'(nrd);
                check("rd_addr", 32'(mem_addr), 32'(ea));
                nrd++;
            end
            if (out_valid) check("rd_in_present", 32'(mem_rd_en), 0);
            if (hs_prev) check("valid_gap", 32'(out_valid), 0);
            if (pend) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(pd));
                check("hold_index", 32'(out_index), 32'(pi));
            end
            if (mode == 0 && out_valid && !pend) begin
                if (k == 0) check("first_latency", c, 3);
                else check("entry_latency", c, last_vc + 3);
                last_vc = c;
            end
            hs_prev = 0;
            if (abort) begin
                aborted = 1; ca = c; pend = 0;
            end else if (out_valid) begin
                if (out_ready) begin
                    ea = base + 8'(k);
                    check("out_data", 32'(out_data), 32'(mem[ea]));
                    check("out_index", 32'(out_index), k);
                    $display("entry idx=%0d data=0x%02h cycle=%0d", out_index, out_data, c);
                    k++; hs_prev = 1;
                end
                pend = !out_ready; pd = out_data; pi = out_index;
            end else pend = 0;
            if (c == done_c + 1) begin
                check("busy_after_done", 32'(busy), 0);
                check("done_width", 32'(done), 0);
                finished = 1;
            end
            if (done) begin
                ndone++; done_c = c;
                check("busy_at_done", 32'(busy), 1);
            end
        end
        abort = 1'b0; start = 1'b0;
        check("no_timeout", 32'(finished), 1);
        if (aborted) begin
            check("abort_delivered", k, abort_idx);
            check("abort_no_done", ndone, 0);
        end else begin
            check("delivered", k, 32'(cnt));
            check("reads", nrd, 32'(cnt));
            check("done_count", ndone, 1);
            if (mode == 0) check("done_cycle", done_c, 3 * int'(cnt) + 1);
        end
        $display("playback base=0x%02h count=%0d mode=%0d entries=%0d reads=%0d done=%0d",
                 base, cnt, mode, k, nrd, ndone);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h0A; mem[8'h12] = 8'h0F; mem[8'h13] = 8'h14;
        mem[8'h40] = 8'hA5; mem[8'h41] = 8'h5A;
        start = 0; abort = 0; out_ready = 0; base_addr = 0; entry_count = 0;
        rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        play(8'h10, 8'd4, 0, -1, 0);   // directed preload sequence
        play(8'hFE, 8'd3, 0, -1, 0);   // address wrap
        play(8'h20, 8'd4, 2, -1, 0);   // backpressure on entry 1
        play(8'h00, 8'd0, 0, -1, 0);   // zero-length start
        play(8'h30, 8'd4, 0, 2, 0);    // abort with same-cycle ready
        play(8'h50, 8'd3, 0, -1, 0);   // replay after abort
        play(8'h60, 8'd3, 0, -1, 2);   // start while busy ignored

        // Asynchronous reset mid-playback, asserted away from any clock edge.
        @(negedge clk);
        base_addr = 8'h40; entry_count = 8'd2; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_rd_en", 32'(mem_rd_en), 1);
        check("pre_reset_data", 32'(out_data), 32'h A5);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_after_reset_busy", 32'(busy), 0);
        check("idle_after_reset_done", 32'(done), 0);
        play(8'h40, 8'd2, 0, -1, 0);

        for (int r = 0; r < 12; r++) begin
            play(8'($urandom), 8'($urandom_range(1, 8)), 1, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
